// File: rtl/attention_pkg.sv
// Shared types and constants for the attention scheduler and the matmul engine.
package attention_pkg;

    localparam int SRAM_ADDR_W = 16;
    localparam int SRAM_DATA_W = 32;

    localparam logic [SRAM_ADDR_W-1:0] ADDR_ONE = SRAM_ADDR_W'(1);

    typedef enum logic [2:0] {
        IDLE,
        HDR_RD,
        HDR_WAIT,
        HDR_CAP,
        CALC,
        ISSUE,
        WAIT_DONE,
        FINISH
    } e_sched_states;

    localparam logic [2:0] JOB_Q = 3'd0;
    localparam logic [2:0] JOB_K = 3'd1;
    localparam logic [2:0] JOB_V = 3'd2;
    localparam logic [2:0] JOB_S = 3'd3;
    localparam logic [2:0] JOB_Z = 3'd4;

    localparam logic [1:0] SEL_INPUT   = 2'd0;
    localparam logic [1:0] SEL_WEIGHT  = 2'd1;
    localparam logic [1:0] SEL_RESULT  = 2'd2;
    localparam logic [1:0] SEL_SCRATCH = 2'd3;

endpackage

// File: rtl/sched_addr_gen.sv
// Per-job base/dimension table; products are registered once per run so the
// multipliers never sit in the FSM's issue path.
module sched_addr_gen
    import attention_pkg::*;
#(
    parameter int DIM_W = 16
) (
    input  logic                   clk,
    input  logic                   reset_n,
    input  logic                   calc_en,
    input  logic [DIM_W-1:0]       dim_m,
    input  logic [DIM_W-1:0]       dim_k,
    input  logic [DIM_W-1:0]       dim_n,
    input  logic [2:0]             job_id,
    output logic [1:0]             a_sel,
    output logic [1:0]             b_sel,
    output logic [1:0]             dst_sel,
    output logic [SRAM_ADDR_W-1:0] a_base,
    output logic [SRAM_ADDR_W-1:0] b_base,
    output logic [SRAM_ADDR_W-1:0] dst_base,
    output logic                   b_transpose,
    output logic [DIM_W-1:0]       job_m,
    output logic [DIM_W-1:0]       job_k,
    output logic [DIM_W-1:0]       job_n
);

    logic [2*DIM_W-1:0]     kn_full, mn_full, mm_full;
    logic [SRAM_ADDR_W-1:0] kn, mn, mm, mn3;

    assign kn_full = dim_k * dim_n;
    assign mn_full = dim_m * dim_n;
    assign mm_full = dim_m * dim_m;

    always_ff @(posedge clk) begin
        if (reset_n) begin
            kn <= '0;
            mn <= '0;
            mm <= '0;
        end else if (calc_en) begin
            kn <= SRAM_ADDR_W'(kn_full);
            mn <= SRAM_ADDR_W'(mn_full);
            mm <= SRAM_ADDR_W'(mm_full);
        end
    end

    assign mn3 = (mn << 1) + mn;

    // Q is the default row; other jobs override only what differs.
    always_comb begin
        a_sel       = SEL_INPUT;
        a_base      = ADDR_ONE;
        b_sel       = SEL_WEIGHT;
        b_base      = ADDR_ONE;
        dst_sel     = SEL_RESULT;
        dst_base    = '0;
        b_transpose = 1'b0;
        job_m       = dim_m;
        job_k       = dim_k;
        job_n       = dim_n;
        case (job_id)
            JOB_K: begin
                b_base   = ADDR_ONE + kn;
                dst_base = mn;
            end
            JOB_V: begin
                b_base   = ADDR_ONE + (kn << 1);
                dst_base = mn << 1;
            end
            JOB_S: begin
                a_sel       = SEL_RESULT;
                a_base      = '0;
                b_sel       = SEL_RESULT;
                b_base      = mn;
                b_transpose = 1'b1;
                dst_base    = mn3;
                job_k       = dim_n;
                job_n       = dim_m;
            end
            JOB_Z: begin
                a_sel    = SEL_SCRATCH;
                a_base   = '0;
                b_sel    = SEL_RESULT;
                b_base   = mn << 1;
                dst_base = mn3 + mm;
                job_k    = dim_m;
            end
            default: ;
        endcase
    end

endmodule

// File: rtl/attention_scheduler.sv
// Self-attention sequencer: fetches SRAM headers, then issues the Q, K, V, S, Z
// GEMM jobs one at a time to the matmul engine.
module attention_scheduler
    import attention_pkg::*;
#(
    parameter int NUM_JOBS = 5,
    parameter int DIM_W    = 16
) (
    input  logic                   clk,
    input  logic                   reset_n,
    input  logic                   dut_valid,
    output logic                   dut_ready,
    output logic [SRAM_ADDR_W-1:0] sched__sram_input_read_address,
    output logic [SRAM_ADDR_W-1:0] sched__sram_weight_read_address,
    input  logic [SRAM_DATA_W-1:0] tb__sched__sram_input_read_data,
    input  logic [SRAM_DATA_W-1:0] tb__sched__sram_weight_read_data,
    output logic                   port_owner,
    output logic                   job_valid,
    input  logic                   job_ready,
    output logic [2:0]             job_id,
    output logic [1:0]             job_a_sel,
    output logic [1:0]             job_b_sel,
    output logic [1:0]             job_dst_sel,
    output logic [SRAM_ADDR_W-1:0] job_a_base,
    output logic [SRAM_ADDR_W-1:0] job_b_base,
    output logic [SRAM_ADDR_W-1:0] job_dst_base,
    output logic                   job_b_transpose,
    output logic [DIM_W-1:0]       job_m,
    output logic [DIM_W-1:0]       job_k,
    output logic [DIM_W-1:0]       job_n,
    input  logic                   eng_done,
    output logic                   cfg_error
);

    localparam logic [2:0] LAST_JOB = 3'(NUM_JOBS - 1);

    e_sched_states    state;
    logic [2:0]       job_cnt;
    logic [DIM_W-1:0] dim_m, dim_k, dim_n;
    logic [DIM_W-1:0] hdr_m, hdr_k, hdr_kw, hdr_n;
    logic             hdr_bad;

    // Both headers live at word 0.
    assign sched__sram_input_read_address  = '0;
    assign sched__sram_weight_read_address = '0;

    assign hdr_m   = tb__sched__sram_input_read_data[31:16];
    assign hdr_k   = tb__sched__sram_input_read_data[15:0];
    assign hdr_kw  = tb__sched__sram_weight_read_data[31:16];
    assign hdr_n   = tb__sched__sram_weight_read_data[15:0];
    assign hdr_bad = (hdr_m == '0) || (hdr_k == '0) || (hdr_n == '0) || (hdr_k != hdr_kw);

    assign job_id = job_cnt;

    always_ff @(posedge clk) begin
        if (reset_n) begin
            state      <= IDLE;
            dut_ready  <= 1'b1;
            port_owner <= 1'b0;
            job_valid  <= 1'b0;
            job_cnt    <= '0;
            cfg_error  <= 1'b0;
            dim_m      <= '0;
            dim_k      <= '0;
            dim_n      <= '0;
        end else begin
            case (state)
                IDLE: begin
                    if (dut_valid) begin
                        state     <= HDR_RD;
                        dut_ready <= 1'b0;
                        cfg_error <= 1'b0;
                        job_cnt   <= '0;
                    end
                end
                HDR_RD:   state <= HDR_WAIT;
                HDR_WAIT: state <= HDR_CAP;
                HDR_CAP: begin
                    dim_m <= hdr_m;
                    dim_k <= hdr_k;
                    dim_n <= hdr_n;
                    if (hdr_bad) begin
                        cfg_error <= 1'b1;
                        state     <= FINISH;
                    end else begin
                        state <= CALC;
                    end
                end
                CALC: begin
                    state      <= ISSUE;
                    job_valid  <= 1'b1;
                    port_owner <= 1'b1;
                end
                ISSUE: begin
                    if (job_ready) begin
                        job_valid <= 1'b0;
                        state     <= WAIT_DONE;
                    end
                end
                WAIT_DONE: begin
                    if (eng_done) begin
                        if (job_cnt == LAST_JOB) begin
                            state      <= FINISH;
                            port_owner <= 1'b0;
                        end else begin
                            job_cnt   <= job_cnt + 3'd1;
                            job_valid <= 1'b1;
                            state     <= ISSUE;
                        end
                    end
                end
                FINISH: begin
                    state     <= IDLE;
                    dut_ready <= 1'b1;
                end
                default: state <= IDLE;
            endcase
        end
    end

    sched_addr_gen #(
        .DIM_W(DIM_W)
    ) u_addr_gen (
        .clk        (clk),
        .reset_n    (reset_n),
        .calc_en    (state == CALC),
        .dim_m      (dim_m),
        .dim_k      (dim_k),
        .dim_n      (dim_n),
        .job_id     (job_cnt),
        .a_sel      (job_a_sel),
        .b_sel      (job_b_sel),
        .dst_sel    (job_dst_sel),
        .a_base     (job_a_base),
        .b_base     (job_b_base),
        .dst_base   (job_dst_base),
        .b_transpose(job_b_transpose),
        .job_m      (job_m),
        .job_k      (job_k),
        .job_n      (job_n)
    );

endmodule

// File: tb/tb_attention_scheduler.sv
// Directed bench for attention_scheduler: header fetch, five-job issue, stalls,
// config errors, mid-run reset and back-to-back runs.
module tb_attention_scheduler;

    logic        clk = 1'b0;
    logic        reset_n = 1'b1;
    logic        dut_valid = 1'b0;
    logic        dut_ready;
    logic [15:0] in_addr, wt_addr;
    logic [31:0] tb__sched__sram_input_read_data = '0;
    logic [31:0] tb__sched__sram_weight_read_data = '0;
    logic        port_owner, job_valid, job_b_transpose, cfg_error;
    logic        job_ready = 1'b0;
    logic        eng_done = 1'b0;
    logic [2:0]  job_id;
    logic [1:0]  job_a_sel, job_b_sel, job_dst_sel;
    logic [15:0] job_a_base, job_b_base, job_dst_base, job_m, job_k, job_n;

    typedef struct packed {
        logic [2:0]  id;
        logic [1:0]  as;
        logic [15:0] ab;
        logic [1:0]  bs;
        logic [15:0] bb;
        logic        tr;
        logic [1:0]  ds;
        logic [15:0] db;
        logic [15:0] m;
        logic [15:0] k;
        logic [15:0] n;
    } job_t;

    job_t obs;
    assign obs = {job_id, job_a_sel, job_a_base, job_b_sel, job_b_base, job_b_transpose,
                  job_dst_sel, job_dst_base, job_m, job_k, job_n};

    int checks = 0;
    int errors = 0;
    int hs_cnt = 0;
    int vld_cyc = 0;

    attention_scheduler dut (
        .clk                             (clk),
        .reset_n                         (reset_n),
        .dut_valid                       (dut_valid),
        .dut_ready                       (dut_ready),
        .sched__sram_input_read_address  (in_addr),
        .sched__sram_weight_read_address (wt_addr),
        .tb__sched__sram_input_read_data (tb__sched__sram_input_read_data),
        .tb__sched__sram_weight_read_data(tb__sched__sram_weight_read_data),
        .port_owner                      (port_owner),
        .job_valid                       (job_valid),
        .job_ready                       (job_ready),
        .job_id                          (job_id),
        .job_a_sel                       (job_a_sel),
        .job_b_sel                       (job_b_sel),
        .job_dst_sel                     (job_dst_sel),
        .job_a_base                      (job_a_base),
        .job_b_base                      (job_b_base),
        .job_dst_base                    (job_dst_base),
        .job_b_transpose                 (job_b_transpose),
        .job_m                           (job_m),
        .job_k                           (job_k),
        .job_n                           (job_n),
        .eng_done                        (eng_done),
        .cfg_error                       (cfg_error)
    );

    always #5 clk = ~clk;

    always @(posedge clk) begin
        if (job_valid && job_ready) hs_cnt <= hs_cnt + 1;
        if (job_valid) vld_cyc <= vld_cyc + 1;
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic check(input string tag, input logic [127:0] got, input logic [127:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
        end
    endtask

    function automatic job_t mk(input int id, input int as, input int ab, input int bs,
                                input int bb, input int tr, input int ds, input int db,
                                input int m, input int k, input int n);
        return {3'(id), 2'(as), 16'(ab), 2'(bs), 16'(bb), 1'(tr), 2'(ds), 16'(db),
                16'(m), 16'(k), 16'(n)};
    endfunction

    // cfg 0: M=2 K=3 N=4 (KN=12, MN=8, MM=4); cfg 1: M=K=N=1. Sel: 0 in, 1 wt, 2 res, 3 scr.
    function automatic job_t exp_job(input int cfg, input int id);
        case (cfg * 8 + id)
            0:  return mk(0, 0, 1, 1, 1,  0, 2, 0,  2, 3, 4);
            1:  return mk(1, 0, 1, 1, 13, 0, 2, 8,  2, 3, 4);
            2:  return mk(2, 0, 1, 1, 25, 0, 2, 16, 2, 3, 4);
            3:  return mk(3, 2, 0, 2, 8,  1, 2, 24, 2, 4, 2);
            4:  return mk(4, 3, 0, 2, 16, 0, 2, 28, 2, 2, 4);
            8:  return mk(0, 0, 1, 1, 1,  0, 2, 0,  1, 1, 1);
            9:  return mk(1, 0, 1, 1, 2,  0, 2, 1,  1, 1, 1);
            10: return mk(2, 0, 1, 1, 3,  0, 2, 2,  1, 1, 1);
            11: return mk(3, 2, 0, 2, 1,  1, 2, 3,  1, 1, 1);
            default: return mk(4, 3, 0, 2, 2, 0, 2, 4, 1, 1, 1);
        endcase
    endfunction

    task automatic start_run(input logic [31:0] in_hdr, input logic [31:0] wt_hdr);
        tb__sched__sram_input_read_data  = in_hdr;
        tb__sched__sram_weight_read_data = wt_hdr;
        dut_valid = 1'b1;
        tick();
        dut_valid = 1'b0;
        check("ready_fall", dut_ready, 0);
        check("hdr_addr", {in_addr, wt_addr}, 0);
        check("cfg_err_clear", cfg_error, 0);
    endtask

    task automatic run_job(input int cfg, input int id, input int hold, input bit noise);
        int n = 0;
        while (!job_valid && n < 20) begin
            tick();
            n++;
        end
        check("job_valid_wait", job_valid, 1);
        check($sformatf("job%0d_fields", id), obs, exp_job(cfg, id));
        check("owner_engine", port_owner, 1);
        for (int i = 0; i < hold; i++) begin
            if (noise && i == 0) begin
                eng_done  = 1'b1;
                dut_valid = 1'b1;
            end
            tick();
            eng_done  = 1'b0;
            dut_valid = 1'b0;
            check("hold_valid", job_valid, 1);
            check("hold_fields", obs, exp_job(cfg, id));
        end
        job_ready = 1'b1;
        tick();
        job_ready = 1'b0;
        check("valid_drop", job_valid, 0);
        repeat (2) tick();
        eng_done = 1'b1;
        tick();
        eng_done = 1'b0;
        if (id < 4) begin
            check("next_valid", job_valid, 1);
        end else begin
            check("finish_ready", dut_ready, 0);
            check("finish_owner", port_owner, 0);
            tick();
            check("ready_back", dut_ready, 1);
        end
    endtask

    task automatic full_run(input int cfg, input logic [31:0] in_hdr, input logic [31:0] wt_hdr,
                            input int hold_id, input bit noise);
        int hs_base = hs_cnt;
        start_run(in_hdr, wt_hdr);
        repeat (3) tick();
        check("early_valid", job_valid, 0);
        tick();
        check("first_valid", job_valid, 1);
        for (int id = 0; id < 5; id++)
            run_job(cfg, id, (id == hold_id) ? 7 : 0, noise && (id == hold_id));
        check("handshakes", hs_cnt - hs_base, 5);
        check("no_cfg_err", cfg_error, 0);
    endtask

    initial begin
        int n;
        int vld_base;

        // Reset state
        repeat (2) tick();
        reset_n = 1'b0;
        check("rst_ready", dut_ready, 1);
        check("rst_valid", job_valid, 0);
        check("rst_owner", port_owner, 0);
        check("rst_cfg_err", cfg_error, 0);
        check("rst_addr", {in_addr, wt_addr}, 0);
        tick();

        // Nominal run with a 7-cycle stall on job 2, plus ignored pulses
        full_run(0, 32'h0002_0003, 32'h0003_0004, 2, 1'b1);

        // K mismatch: no jobs, error flag, back to idle
        vld_base = vld_cyc;
        start_run(32'h0002_0003, 32'h0004_0004);
        n = 0;
        while (!dut_ready && n < 10) begin
            tick();
            n++;
        end
        check("err_ready_back", dut_ready, 1);
        check("err_flag", cfg_error, 1);
        check("err_no_jobs", vld_cyc - vld_base, 0);
        tick();
        check("err_sticky", cfg_error, 1);

        // Reset during WAIT_DONE of job 3, then a clean run
        start_run(32'h0002_0003, 32'h0003_0004);
        for (int id = 0; id < 3; id++) run_job(0, id, 0, 1'b0);
        check("job3_fields", obs, exp_job(0, 3));
        job_ready = 1'b1;
        tick();
        job_ready = 1'b0;
        tick();
        reset_n = 1'b1;
        tick();
        check("mid_rst_ready", dut_ready, 1);
        check("mid_rst_valid", job_valid, 0);
        check("mid_rst_owner", port_owner, 0);
        check("mid_rst_id", job_id, 0);
        check("mid_rst_cfg_err", cfg_error, 0);
        reset_n = 1'b0;
        tick();
        full_run(0, 32'h0002_0003, 32'h0003_0004, 5, 1'b0);

        // Back-to-back unit-size runs
        full_run(1, 32'h0001_0001, 32'h0001_0001, 5, 1'b0);
        full_run(1, 32'h0001_0001, 32'h0001_0001, 1, 1'b0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
